// File: rtl/mmu_mem_responder.sv
// mmu_mem_responder
// Memory-side responder for the MMU page-walk channel. It accepts PTE read
// requests by physical byte address, looks them up in a small preloadable
// table, and returns {err, pte} in order after a fixed latency. The request
// side is flow-controlled by an outstanding-request counter, so the output
// FIFO always has room for everything that is in flight.

module mmu_mem_responder #(
    parameter int                 PA_BITS  = 40,
    parameter int                 PTE_BITS = 64,
    parameter int                 IDX_BITS = 6,
    parameter logic [PA_BITS-1:0] BASE     = PA_BITS'(40'h00_8000_0000),
    parameter int                 LAT      = 4,
    parameter int                 QDEPTH   = 8
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                mem_req_i_valid,
    output logic                mem_req_i_ready,
    input  logic [PA_BITS-1:0]  mem_req_i_bits,

    output logic                mem_resp_o_valid,
    input  logic                mem_resp_o_ready,
    output logic                mem_resp_o_bits_err,
    output logic [PTE_BITS-1:0] mem_resp_o_bits_pte,

    input  logic                wr_i_valid,
    input  logic [IDX_BITS-1:0] wr_i_idx,
    input  logic [PTE_BITS-1:0] wr_i_data,

    output logic [15:0]         err_cnt_o
);

    localparam int TBL_N = 1 << IDX_BITS;
    localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW    = $clog2(QDEPTH + 1);

    // PTE table
    logic [PTE_BITS-1:0] tbl [TBL_N];

    // Handshakes
    logic accept;
    logic resp_fire;

    // Decode of the request presented this cycle
    logic                hit;
    logic [IDX_BITS-1:0] req_idx;
    logic                dec_err;
    logic [PTE_BITS-1:0] dec_pte;

    // Output of the latency pipeline, feeding the response FIFO
    logic                fin_v;
    logic                fin_err;
    logic [PTE_BITS-1:0] fin_pte;

    // Outstanding requests: in the pipeline plus waiting in the FIFO
    logic [CW-1:0] cnt;

    // Response FIFO
    logic [PTE_BITS:0] fifo_mem [QDEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic [PTE_BITS:0] head;

    logic [15:0] err_cnt;

    // Circular pointer advance that also works for non-power-of-two depths
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on the outstanding count, and is held low during reset
    assign mem_req_i_ready = !reset && (cnt < CW'(QDEPTH));
    assign accept          = mem_req_i_valid && mem_req_i_ready;
    assign resp_fire       = mem_resp_o_valid && mem_resp_o_ready;

    // Window/alignment decode and table read, with bypass of a same-cycle write
    always_comb begin
        hit     = (mem_req_i_bits[PA_BITS-1:IDX_BITS+3] == BASE[PA_BITS-1:IDX_BITS+3])
                  && (mem_req_i_bits[2:0] == 3'b000);
        req_idx = mem_req_i_bits[IDX_BITS+2:3];
        dec_err = !hit;
        dec_pte = '0;
        if (hit) begin
            if (wr_i_valid && (wr_i_idx == req_idx)) begin
                dec_pte = wr_i_data;
            end else begin
                dec_pte = tbl[req_idx];
            end
        end
    end

    // Table preload writes; reset clears every entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TBL_N; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_i_valid) begin
            tbl[wr_i_idx] <= wr_i_data;
        end
    end

    // LAT-1 register stages between decode and the FIFO; with LAT=1 the decode
    // result is written straight into the FIFO at the accept edge
    generate
        if (LAT > 1) begin : g_pipe
            localparam int NS = LAT - 1;

            logic [NS-1:0]       stg_v;
            logic [NS-1:0]       stg_err;
            logic [PTE_BITS-1:0] stg_pte [NS];

            // Shift decoded responses one stage per cycle
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stg_v   <= '0;
                    stg_err <= '0;
                    for (int i = 0; i < NS; i++) begin
                        stg_pte[i] <= '0;
                    end
                end else begin
                    stg_v[0]   <= accept;
                    stg_err[0] <= dec_err;
                    stg_pte[0] <= dec_pte;
                    for (int i = 1; i < NS; i++) begin
                        stg_v[i]   <= stg_v[i-1];
                        stg_err[i] <= stg_err[i-1];
                        stg_pte[i] <= stg_pte[i-1];
                    end
                end
            end

            assign fin_v   = stg_v[NS-1];
            assign fin_err = stg_err[NS-1];
            assign fin_pte = stg_pte[NS-1];
        end else begin : g_nopipe
            assign fin_v   = accept;
            assign fin_err = dec_err;
            assign fin_pte = dec_pte;
        end
    endgenerate

    // FIFO storage; contents need no reset because the head is gated by valid
    always_ff @(posedge clock) begin
        if (fin_v) begin
            fifo_mem[wr_ptr] <= {fin_err, fin_pte};
        end
    end

    // FIFO pointers and occupancy; cnt bounds occupancy so a push never overflows
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fin_v) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (resp_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({fin_v, resp_fire})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Outstanding count: up on accept, down on response handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({accept, resp_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Saturating count of handshaked error responses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (resp_fire && mem_resp_o_bits_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign head                = fifo_mem[rd_ptr];
    assign mem_resp_o_valid    = (fifo_cnt != '0);
    assign mem_resp_o_bits_err = mem_resp_o_valid && head[PTE_BITS];
    assign mem_resp_o_bits_pte = mem_resp_o_valid ? head[PTE_BITS-1:0] : '0;
    assign err_cnt_o           = err_cnt;

endmodule

// File: tb/tb_mmu_mem_responder.sv
// tb_mmu_mem_responder
// Directed scenarios followed by a randomized phase. A reference model keeps
// the table as an array and the expected responses as a queue tagged with the
// earliest cycle each may appear; every cycle the DUT outputs are compared
// against that model.

module tb_mmu_mem_responder;

    localparam int          PA_BITS  = 40;
    localparam int          PTE_BITS = 64;
    localparam int          IDX_BITS = 6;
    localparam logic [39:0] BASE     = 40'h00_8000_0000;
    localparam int          LAT      = 4;
    localparam int          QDEPTH   = 8;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                mem_req_i_valid = 1'b0;
    logic                mem_req_i_ready;
    logic [PA_BITS-1:0]  mem_req_i_bits = '0;
    logic                mem_resp_o_valid;
    logic                mem_resp_o_ready = 1'b0;
    logic                mem_resp_o_bits_err;
    logic [PTE_BITS-1:0] mem_resp_o_bits_pte;
    logic                wr_i_valid = 1'b0;
    logic [IDX_BITS-1:0] wr_i_idx = '0;
    logic [PTE_BITS-1:0] wr_i_data = '0;
    logic [15:0]         err_cnt_o;

    mmu_mem_responder #(
        .PA_BITS (PA_BITS),
        .PTE_BITS(PTE_BITS),
        .IDX_BITS(IDX_BITS),
        .BASE    (BASE),
        .LAT     (LAT),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mem_req_i_valid    (mem_req_i_valid),
        .mem_req_i_ready    (mem_req_i_ready),
        .mem_req_i_bits     (mem_req_i_bits),
        .mem_resp_o_valid   (mem_resp_o_valid),
        .mem_resp_o_ready   (mem_resp_o_ready),
        .mem_resp_o_bits_err(mem_resp_o_bits_err),
        .mem_resp_o_bits_pte(mem_resp_o_bits_pte),
        .wr_i_valid         (wr_i_valid),
        .wr_i_idx           (wr_i_idx),
        .wr_i_data          (wr_i_data),
        .err_cnt_o          (err_cnt_o)
    );

    // Free-running clock
    always #5 clock = ~clock;

    typedef struct {
        logic        err;
        logic [63:0] pte;
        longint      due;
    } resp_t;

    resp_t       expQ[$];
    logic [63:0] mTable [64];
    int          mCnt;
    int          mErrCnt;
    longint      cyc;
    longint      callCyc;

    int checks;
    int failures;

    logic        dutAccept;
    logic        dutHs;
    logic        dutErr;
    logic [63:0] dutPte;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference decode: in-window, 8-byte aligned addresses hit the table
    function automatic void modelDecode(input logic [39:0] a, input logic wv, input logic [5:0] wi,
                                        input logic [63:0] wd, output logic err, output logic [63:0] pte);
        longint unsigned off;
        if ((a >= BASE) && (a < BASE + 40'd512) && ((a % 8) == 0)) begin
            off = (a - BASE) / 8;
            err = 1'b0;
            pte = (wv && (wi == off[5:0])) ? wd : mTable[off];
        end else begin
            err = 1'b1;
            pte = '0;
        end
    endfunction

    // One cycle: check outputs against the model, drive inputs, advance the model
    task automatic applyStimulus(input logic rv, input logic [39:0] ra, input logic wv,
                                 input logic [5:0] wi, input logic [63:0] wd, input logic rr);
        logic  expReady;
        logic  expValid;
        resp_t e;
        @(negedge clock);
        expReady = (mCnt < QDEPTH);
        expValid = (expQ.size() > 0) && (expQ[0].due <= cyc);
        checkOutput("req_ready", {63'd0, mem_req_i_ready}, {63'd0, expReady});
        checkOutput("resp_valid", {63'd0, mem_resp_o_valid}, {63'd0, expValid});
        if (expValid) begin
            checkOutput("resp_err", {63'd0, mem_resp_o_bits_err}, {63'd0, expQ[0].err});
            checkOutput("resp_pte", mem_resp_o_bits_pte, expQ[0].pte);
        end
        checkOutput("err_cnt", {48'd0, err_cnt_o}, 64'(mErrCnt));

        mem_req_i_valid  = rv;
        mem_req_i_bits   = ra;
        wr_i_valid       = wv;
        wr_i_idx         = wi;
        wr_i_data        = wd;
        mem_resp_o_ready = rr;

        dutAccept = rv && mem_req_i_ready;
        dutHs     = mem_resp_o_valid && rr;
        dutErr    = mem_resp_o_bits_err;
        dutPte    = mem_resp_o_bits_pte;
        callCyc   = cyc;

        if (expValid && rr) begin
            if (expQ[0].err && (mErrCnt < 65535)) mErrCnt++;
            void'(expQ.pop_front());
            mCnt--;
        end
        if (rv && expReady) begin
            modelDecode(ra, wv, wi, wd, e.err, e.pte);
            e.due = cyc + LAT;
            expQ.push_back(e);
            mCnt++;
        end
        if (wv) mTable[wi] = wd;
        cyc++;
    endtask

    // One-cycle reset pulse asserted asynchronously between edges
    task automatic doReset();
        @(negedge clock);
        reset            = 1'b1;
        mem_req_i_valid  = 1'b0;
        wr_i_valid       = 1'b0;
        mem_resp_o_ready = 1'b0;
        #1;
        checkOutput("reset_ready", {63'd0, mem_req_i_ready}, 64'd0);
        checkOutput("reset_valid", {63'd0, mem_resp_o_valid}, 64'd0);
        checkOutput("reset_errcnt", {48'd0, err_cnt_o}, 64'd0);
        checkOutput("reset_pte", mem_resp_o_bits_pte, 64'd0);
        expQ.delete();
        mCnt    = 0;
        mErrCnt = 0;
        for (int i = 0; i < 64; i++) mTable[i] = '0;
        @(negedge clock);
        reset = 1'b0;
        cyc += 2;
    endtask

    // Idle with resp_ready high until the DUT hands over a response
    task automatic waitResponse(output longint hc);
        hc = -1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
            if (dutHs) begin
                hc = callCyc;
                return;
            end
        end
        checkOutput("resp_timeout", 64'd0, 64'd1);
    endtask

    longint      accCyc;
    longint      hsCyc;
    longint      firstAcc;
    longint      firstHs;
    longint      lastHs;
    int          nAcc;
    int          nResp;
    int          nHs;
    logic [63:0] rnd;
    logic [39:0] addr;

    // Watchdog so the run can never hang
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence
    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        doReset();

        // Basic hit with latency measurement
        applyStimulus(1'b0, '0, 1'b1, 6'd5, 64'hDEAD_BEEF_0000_0001, 1'b1);
        applyStimulus(1'b1, 40'h00_8000_0028, 1'b0, '0, '0, 1'b1);
        accCyc = callCyc;
        checkOutput("s1_accept", {63'd0, dutAccept}, 64'd1);
        waitResponse(hsCyc);
        checkOutput("s1_latency", 64'(hsCyc - accCyc), 64'd4);
        checkOutput("s1_err", {63'd0, dutErr}, 64'd0);
        checkOutput("s1_pte", dutPte, 64'hDEAD_BEEF_0000_0001);

        // Out-of-window and misaligned requests
        applyStimulus(1'b1, 40'h00_8000_0200, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 40'h00_8000_0004, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            waitResponse(hsCyc);
            checkOutput("s2_err", {63'd0, dutErr}, 64'd1);
            checkOutput("s2_pte", dutPte, 64'd0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("s2_errcnt", {48'd0, err_cnt_o}, 64'd2);

        // Backpressure: queue fills at QDEPTH, then drains in order
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 6'(k), 64'hA000 + 64'(k), 1'b0);
        end
        nAcc = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, BASE + 40'(8 * nAcc), 1'b0, '0, '0, 1'b0);
            if (dutAccept) nAcc++;
        end
        checkOutput("s3_accepted", 64'(nAcc), 64'd8);
        checkOutput("s3_ready_low", {63'd0, mem_req_i_ready}, 64'd0);
        nResp = 0;
        for (int k = 0; k < 60 && nResp < 10; k++) begin
            applyStimulus(nAcc < 10, BASE + 40'(8 * nAcc), 1'b0, '0, '0, 1'b1);
            if (dutAccept) nAcc++;
            if (dutHs) begin
                checkOutput("s3_order", dutPte, 64'hA000 + 64'(nResp));
                nResp++;
            end
        end
        checkOutput("s3_responses", 64'(nResp), 64'd10);

        // Same-cycle write and read of one entry returns the new data
        applyStimulus(1'b1, 40'h00_8000_0018, 1'b1, 6'd3, 64'h1234, 1'b1);
        waitResponse(hsCyc);
        checkOutput("s4_bypass", dutPte, 64'h1234);

        // Reset with requests in flight discards them and clears the table
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, BASE + 40'(8 * k), 1'b0, '0, '0, 1'b1);
        end
        doReset();
        #1;
        checkOutput("s5_ready", {63'd0, mem_req_i_ready}, 64'd1);
        nHs = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
            if (dutHs) nHs++;
        end
        checkOutput("s5_no_resp", 64'(nHs), 64'd0);
        applyStimulus(1'b1, 40'h00_8000_0028, 1'b0, '0, '0, 1'b1);
        waitResponse(hsCyc);
        checkOutput("s5_pte", dutPte, 64'd0);

        // Sustained throughput of one request per cycle
        nAcc = 0; nHs = 0; firstAcc = -1; firstHs = -1; lastHs = -1;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b1, BASE + 40'(8 * (k % 64)), 1'b0, '0, '0, 1'b1);
            if (dutAccept) begin
                if (firstAcc < 0) firstAcc = callCyc;
                nAcc++;
            end
            if (dutHs) begin
                if (firstHs < 0) firstHs = callCyc;
                lastHs = callCyc;
                nHs++;
            end
        end
        for (int k = 0; k < 20 && nHs < 100; k++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
            if (dutHs) begin
                lastHs = callCyc;
                nHs++;
            end
        end
        checkOutput("s6_accepts", 64'(nAcc), 64'd100);
        checkOutput("s6_responses", 64'(nHs), 64'd100);
        checkOutput("s6_first_lat", 64'(firstHs - firstAcc), 64'd4);
        checkOutput("s6_back_to_back", 64'(lastHs - firstHs), 64'd99);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rnd = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4, 5: addr = BASE + 40'(8 * $urandom_range(0, 63));
                6:                addr = BASE + 40'($urandom_range(0, 511));
                default:          addr = rnd[39:0];
            endcase
            applyStimulus($urandom_range(0, 1) == 1, addr, $urandom_range(0, 3) == 0,
                          6'($urandom_range(0, 63)), {$urandom, $urandom}, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 100 && expQ.size() > 0; k++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        end
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
